// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-requester data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } arb_state_e;

    localparam int NUM_REQ = 2;
    localparam int DEF_AW  = 8;
    localparam int DEF_DW  = 8;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with bounded burst lock, muxing a core and a loader
// onto a single-port data memory with a registered read-data return.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_LOCK = 16,
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] Req,
    input  logic [NUM_REQ-1:0] We,
    input  logic [NUM_REQ-1:0] Lock,
    input  logic [AW-1:0]      Addr0,
    input  logic [AW-1:0]      Addr1,
    input  logic [DW-1:0]      WData0,
    input  logic [DW-1:0]      WData1,
    output logic [NUM_REQ-1:0] Gnt,
    output logic [NUM_REQ-1:0] RdValid,
    output logic [DW-1:0]      RData,
    output logic               MemWriteEn,
    output logic [AW-1:0]      MemAddress,
    output logic [DW-1:0]      MemDataIn,
    input  logic [DW-1:0]      MemDataOut
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

    arb_state_e          state_q, state_d;
    logic                rr_q, rr_d;
    logic [CW-1:0]       lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0]  rdvalid_q, rdvalid_d;
    logic [DW-1:0]       rdata_q, rdata_d;

    logic pick;
    logic sel;
    logic granted;
    logic cur_req;
    logic cur_we;
    logic cur_lock;
    logic other_req;
    logic access;

    // Requester chosen from IDLE; RR only breaks a tie.
    always_comb begin
        pick = Req[1];
        if (Req == 2'b11) begin
            pick = rr_q;
        end
    end

    assign sel       = (state_q == G1);
    assign granted   = (state_q != IDLE);
    assign cur_req   = Req[sel];
    assign cur_we    = We[sel];
    assign cur_lock  = Lock[sel];
    assign other_req = Req[~sel];
    assign access    = granted & cur_req;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            IDLE: begin
                if (|Req) begin
                    state_d = pick ? G1 : G0;
                end
            end
            G0, G1: begin
                if (cur_req && cur_lock && (lock_cnt_q < CNT_MAX)) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end else if (other_req) begin
                    state_d    = sel ? G0 : G1;
                    lock_cnt_d = '0;
                    rr_d       = sel;
                end else if (cur_req) begin
                    // Sole requester keeps the grant; a held lock stays saturated.
                    lock_cnt_d = cur_lock ? lock_cnt_q : '0;
                end else begin
                    state_d    = IDLE;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        rdvalid_d = '0;
        rdata_d   = rdata_q;
        if (access && !cur_we) begin
            rdata_d   = MemDataOut;
            rdvalid_d = sel ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            lock_cnt_q <= '0;
            rdvalid_q  <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_cnt_q <= lock_cnt_d;
            rdvalid_q  <= rdvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    // Reset gates the write strobe so an in-flight grant never commits.
    assign MemWriteEn = access & cur_we & Reset;
    assign MemAddress = granted ? (sel ? Addr1 : Addr0) : '0;
    assign MemDataIn  = granted ? (sel ? WData1 : WData0) : '0;

    assign Gnt     = {state_q == G1, state_q == G0};
    assign RdValid = rdvalid_q;
    assign RData   = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized check of dmem_arbiter against a cycle-level
// behavioural model with its own shadow memory.
module tb_dmem_arbiter;

    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int MAX_LOCK = 16;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [1:0]    Req, We, Lock;
    logic [AW-1:0] Addr0, Addr1;
    logic [DW-1:0] WData0, WData1;
    logic [1:0]    Gnt, RdValid;
    logic [DW-1:0] RData;
    logic          MemWriteEn;
    logic [AW-1:0] MemAddress;
    logic [DW-1:0] MemDataIn;
    logic [DW-1:0] MemDataOut;

    logic [DW-1:0] phys_mem [2**AW];
    logic [DW-1:0] ref_mem  [2**AW];

    int n_vec  = 0;
    int n_miss = 0;
    int wen_cycles = 0;

    int         m_gnt;
    int         m_cnt;
    int         m_rr;
    logic [1:0] m_rdv;
    logic [DW-1:0] m_rdata;

    always #5 Clk = ~Clk;

    assign MemDataOut = phys_mem[MemAddress];

    dmem_arbiter #(.MAX_LOCK(MAX_LOCK), .AW(AW), .DW(DW)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .Lock(Lock),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Gnt(Gnt), .RdValid(RdValid), .RData(RData),
        .MemWriteEn(MemWriteEn), .MemAddress(MemAddress),
        .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int x);
        return (x == 1) ? Addr1 : Addr0;
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int x);
        return (x == 1) ? WData1 : WData0;
    endfunction

    // Apply the spec's arbitration rules for one clock edge.
    task automatic model_update();
        int x, y;
        if (!Reset) begin
            m_gnt = -1; m_cnt = 0; m_rr = 0; m_rdv = 2'b00; m_rdata = '0;
            return;
        end
        m_rdv = 2'b00;
        if (m_gnt >= 0) begin
            x = m_gnt;
            y = 1 - x;
            if (Req[x]) begin
                if (We[x]) ref_mem[addr_of(x)] = wdata_of(x);
                else begin
                    m_rdata  = ref_mem[addr_of(x)];
                    m_rdv[x] = 1'b1;
                end
            end
            if (Req[x] && Lock[x] && m_cnt < MAX_LOCK) m_cnt = m_cnt + 1;
            else if (Req[y]) begin m_gnt = y; m_cnt = 0; m_rr = x; end
            else if (Req[x]) m_cnt = Lock[x] ? m_cnt : 0;
            else begin m_gnt = -1; m_cnt = 0; end
        end else begin
            if (Req == 2'b11) m_gnt = m_rr;
            else if (Req[0])  m_gnt = 0;
            else if (Req[1])  m_gnt = 1;
        end
    endtask

    task automatic step();
        logic          e_wen;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        logic          c_wen;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_din;
        #2;
        e_wen  = 1'b0;
        e_addr = '0;
        e_din  = '0;
        if (m_gnt >= 0) begin
            e_addr = addr_of(m_gnt);
            e_din  = wdata_of(m_gnt);
            e_wen  = Req[m_gnt] & We[m_gnt] & Reset;
        end
        check("wen",  MemWriteEn, e_wen);
        check("addr", MemAddress, e_addr);
        check("din",  MemDataIn,  e_din);
        c_wen = MemWriteEn; c_addr = MemAddress; c_din = MemDataIn;
        @(posedge Clk);
        if (c_wen) begin
            phys_mem[c_addr] = c_din;
            wen_cycles++;
        end
        model_update();
        #1;
        check("gnt",     Gnt, (m_gnt == 0) ? 2'b01 : (m_gnt == 1) ? 2'b10 : 2'b00);
        check("rdvalid", RdValid, m_rdv);
        check("rdata",   RData, m_rdata);
    endtask

    task automatic set_in(input logic rst, input logic [1:0] r, input logic [1:0] w,
                          input logic [1:0] l);
        Reset = rst; Req = r; We = w; Lock = l;
    endtask

    initial begin
        logic [DW-1:0] old;
        logic [1:0]    seq [4];
        int            run;
        int            w0;

        for (int i = 0; i < 2**AW; i++) begin
            phys_mem[i] = DW'($urandom);
            ref_mem[i]  = phys_mem[i];
        end
        phys_mem[16] = 8'd254;
        ref_mem[16]  = 8'd254;
        m_gnt = -1; m_cnt = 0; m_rr = 0; m_rdv = 2'b00; m_rdata = '0;
        Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0;

        set_in(1'b0, 2'b00, 2'b00, 2'b00);
        step(); step();
        check("reset_gnt", Gnt, 2'b00);

        // Single core read of mem[16]
        set_in(1'b1, 2'b01, 2'b00, 2'b00); Addr0 = 8'd16;
        step();
        check("rd_gnt", Gnt, 2'b01);
        step();
        check("rd_valid", RdValid, 2'b01);
        check("rd_data", RData, 8'd254);
        set_in(1'b1, 2'b00, 2'b00, 2'b00);
        step();

        // Loader write 0xA5 to 244, then read it back
        w0 = wen_cycles;
        set_in(1'b1, 2'b10, 2'b10, 2'b00); Addr1 = 8'd244; WData1 = 8'hA5;
        step(); step();
        We = 2'b00;
        step();
        check("wr_rd_data", RData, 8'hA5);
        check("wr_rd_valid", RdValid, 2'b10);
        set_in(1'b1, 2'b00, 2'b00, 2'b00);
        step();
        check("wr_once", wen_cycles - w0, 1);

        // Reset during a loader write grant
        Addr1 = 8'd200; old = phys_mem[200]; WData1 = ~old;
        set_in(1'b1, 2'b10, 2'b10, 2'b00);
        step();
        check("mid_gnt", Gnt, 2'b10);
        Reset = 1'b0;
        step();
        check("mid_gnt_off", Gnt, 2'b00);
        check("mid_rdv_off", RdValid, 2'b00);
        check("mid_mem", phys_mem[200], old);
        set_in(1'b1, 2'b00, 2'b00, 2'b00);
        step();

        // Request dropped while granted
        set_in(1'b1, 2'b01, 2'b01, 2'b00); Addr0 = 8'd5; WData0 = 8'h3C;
        step();
        w0 = wen_cycles;
        Req = 2'b00;
        step();
        check("drop_nowr", wen_cycles - w0, 0);
        check("drop_gnt", Gnt, 2'b00);
        check("drop_rdv", RdValid, 2'b00);

        // Contention with no locks, from reset
        set_in(1'b0, 2'b00, 2'b00, 2'b00); step();
        set_in(1'b1, 2'b11, 2'b00, 2'b00);
        for (int i = 0; i < 4; i++) begin
            step();
            seq[i] = Gnt;
        end
        check("cont_0", seq[0], 2'b01);
        check("cont_1", seq[1], 2'b10);
        check("cont_2", seq[2], 2'b01);
        check("cont_3", seq[3], 2'b10);

        // Lock cap: core locked against a waiting loader
        set_in(1'b0, 2'b00, 2'b00, 2'b00); step();
        set_in(1'b1, 2'b11, 2'b00, 2'b01);
        run = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (Gnt != 2'b01) break;
            run++;
        end
        check("lock_run", run, MAX_LOCK + 1);
        check("lock_next", Gnt, 2'b10);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            Reset  = ($urandom_range(63) != 0);
            Req    = 2'($urandom);
            We     = 2'($urandom);
            Lock   = {($urandom_range(3) == 0), ($urandom_range(3) == 0)};
            Addr0  = AW'($urandom);
            Addr1  = AW'($urandom);
            WData0 = DW'($urandom);
            WData1 = DW'($urandom);
            step();
        end

        for (int i = 0; i < 2**AW; i++) begin
            if (phys_mem[i] !== ref_mem[i]) check("mem_final", phys_mem[i], ref_mem[i]);
        end
        check("mem_16", phys_mem[16], ref_mem[16]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters: MAX_LOCK, default 16, max consecutive grants one requester may hold while the other is requesting.
REQ-002 Parameters: AW, default 8, address width; DW, default 8, data width.
REQ-003 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-low (0 = reset), sampled on posedge Clk.
REQ-005 Req[1:0]  input  2  access request per requester (0 = core, 1 = loader).
REQ-006 We[1:0]  input  2  per-requester write (1) / read (0) select.
REQ-007 Lock[1:0]  input  2  per-requester burst hold request.
REQ-008 Addr0, Addr1  input  AW each  per-requester address.
REQ-009 WData0, WData1  input  DW each  per-requester write data.
REQ-010 Gnt[1:0]  output  2  registered one-hot-or-zero grant.
REQ-011 RdValid[1:0]  output  2  registered read-data-valid per requester.
REQ-012 RData  output  DW  registered read data, shared by both requesters.
REQ-013 MemWriteEn  output  1  drives the data memory WriteEn.
REQ-014 MemAddress  output  AW  drives the data memory DataAddress.
REQ-015 MemDataIn  output  DW  drives the data memory DataIn.
REQ-016 MemDataOut  input  DW  combinational read data from the data memory.

Function
REQ-017 FSM states IDLE, G0, G1; the state is registered and Gnt = {state==G1, state==G0}.
REQ-018 IDLE: if no Req, stay in IDLE; if one Req, go to its G state; if both, go to the state named by the round-robin pointer RR.
REQ-019 Latency: Req high in cycle N from IDLE gives Gnt in cycle N+1; one access is performed per Gnt cycle.
REQ-020 A requester SHALL hold Req/We/Addr/WData stable until it sees Gnt; the arbiter does not check this.
REQ-021 During Gx: MemAddress = Addrx, MemDataIn = WDatax, MemWriteEn = Wex & Reqx.
REQ-022 In IDLE: MemWriteEn = 0; MemAddress and MemDataIn = 0.
REQ-023 Reads: in a Gx cycle with Wex=0, RData <= MemDataOut and RdValid[x] = 1 in the next cycle only; otherwise RdValid = 0 and RData holds its value.
REQ-024 Leaving Gx, when Reqx && Lockx && LockCnt < MAX_LOCK: stay in Gx and increment LockCnt.
REQ-025 Leaving Gx, when the other requester is requesting (lock not applicable or exhausted): switch to the other G state, clear LockCnt, and set RR to point at x (the requester just served).
REQ-026 Leaving Gx, when only Reqx is active: stay in Gx; LockCnt increments only while Lockx=1, otherwise it clears.
REQ-027 Leaving Gx, when no Req: go to IDLE and clear LockCnt.
REQ-028 LockCnt is ceil(log2(MAX_LOCK+1)) bits wide and saturates at MAX_LOCK; the cap forces release only if the other requester is requesting.
REQ-029 A Gx cycle in which Reqx=0 performs no write and produces no RdValid.
REQ-030 Simultaneous first requests from IDLE with RR=0 grant requester 0 first.

Reset
REQ-031 With Reset=0 at a clock edge: state <= IDLE, RR <= 0, LockCnt <= 0, Gnt <= 0, RdValid <= 0, RData <= 0.
REQ-032 MemWriteEn SHALL be forced to 0 combinationally while Reset=0, so a mid-grant reset drops the pending access with no memory write.
REQ-033 Reset does not clear memory contents; memory initialisation belongs to the memory itself.

Structure
REQ-034 Shared package dmem_arb_pkg holds the state enum (IDLE, G0, G1), NUM_REQ = 2, and the default AW/DW.
REQ-035 The block is a single module with no sub-module; the round-robin pick is a local combinational block.

Verification
REQ-036 Single read: core Req=1, We=0, Addr0=16 with mem[16]=254 -> Gnt=01 at N+1, RdValid=01 and RData=254 at N+2.
REQ-037 Write then read: loader writes 0xA5 to 244, then reads 244 -> MemWriteEn high exactly one cycle, then RData=0xA5.
REQ-038 Contention: both Req held, Lock=00, from reset -> Gnt sequence 01, 10, 01, 10.
REQ-039 Lock cap: core Lock=1 Req=1, loader Req=1, MAX_LOCK=16 -> core granted 17 consecutive cycles, then Gnt=10.
REQ-040 Mid-op reset: Reset=0 during a G1 write cycle -> MemWriteEn=0, next cycle Gnt=00 and RdValid=00; the memory location is unchanged.
REQ-041 Drop: Req falls while granted -> that Gnt cycle produces no write and no RdValid; state returns to IDLE.
